// File: rtl/axis_counter_pkg.sv
// Shared definitions for the counter-pattern stream source and checker.
package axis_counter_pkg;

    localparam int FRAME_ID_W = 24;
    localparam int BEAT_W     = 8;

    // Bit positions inside the {keep, last, data} error vector
    localparam int ERR_DATA = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_KEEP = 2;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_RESYNC = 1'b1
    } chk_state_t;

    // Beat payload of the counter pattern before truncation to the bus width
    function automatic logic [31:0] exp_word(input logic [FRAME_ID_W-1:0] frame,
                                             input logic [BEAT_W-1:0]     beat);
        return {frame, beat};
    endfunction

endpackage

// File: rtl/axis_ready_shaper.sv
// Back-pressure generator: a rotating pattern register gated by enable drives tready.
module axis_ready_shaper #(
    parameter logic [31:0] READY_PAT = 32'hFFFF_FFFF
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic enable,
    output logic tready
);

    logic [31:0] pat;

    // Pattern rotates right every clock regardless of handshakes; tready is registered
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pat    <= READY_PAT;
            tready <= 1'b0;
        end else begin
            pat    <= {pat[0], pat[31:1]};
            tready <= enable & pat[0];
        end
    end

endmodule

// File: rtl/axis_counter_chk.sv
// AXI4-Stream sink that checks the counter-pattern stream and keeps frame/error statistics.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_SYNC   | locked: every accepted beat is checked against {frame, beat}
//  ST_RESYNC | lost lock: beats discarded until a tlast re-seeds the frame id
module axis_counter_chk
    import axis_counter_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          KEEP_W      = DATA_W / 8,
    parameter int          USER_W      = 1,
    parameter int          FRAME_BEATS = 8,
    parameter logic [31:0] READY_PAT   = 32'hFFFF_FFFF,
    parameter int          ERR_W       = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic [31:0]       frames_ok,
    output logic [ERR_W-1:0]  err_count,
    output logic [2:0]        err_sticky,
    output logic              err_pulse,
    output logic              in_sync
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    chk_state_t            state;
    chk_state_t            state_nxt;
    logic [FRAME_ID_W-1:0] exp_frame;
    logic [BEAT_W-1:0]     exp_beat;
    logic                  accept;
    logic [2:0]            beat_err;
    logic [31:0]           exp_w;
    logic [31:0]           tdata32;
    logic [DATA_W-1:0]     exp_data;
    logic                  unused_bits;

    axis_ready_shaper #(
        .READY_PAT (READY_PAT)
    ) u_ready (
        .aclk    (aclk),
        .aresetn (aresetn),
        .enable  (enable),
        .tready  (s_axis_tready)
    );

    assign accept = s_axis_tvalid & s_axis_tready;
    assign exp_w  = exp_word(exp_frame, exp_beat);

    // Bus-width adaptation: bits above 32 are expected zero, narrow buses see a truncated word
    generate
        if (DATA_W > 32) begin : g_wide
            assign exp_data = {{(DATA_W-32){1'b0}}, exp_w};
            assign tdata32  = s_axis_tdata[31:0];
        end else if (DATA_W == 32) begin : g_exact
            assign exp_data = exp_w;
            assign tdata32  = s_axis_tdata;
        end else begin : g_narrow
            assign exp_data = exp_w[DATA_W-1:0];
            assign tdata32  = {{(32-DATA_W){1'b0}}, s_axis_tdata};
        end
    endgenerate

    // tuser is not checked; only the frame id field of tdata32 is used for resync
    assign unused_bits = ^{s_axis_tuser, tdata32[7:0], exp_w};

    // Per-beat checks against the expected pattern position
    always_comb begin
        beat_err           = '0;
        beat_err[ERR_DATA] = (s_axis_tdata != exp_data);
        beat_err[ERR_LAST] = (s_axis_tlast != (exp_beat == LAST_BEAT));
        beat_err[ERR_KEEP] = (s_axis_tkeep != {KEEP_W{1'b1}});
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: an error on a beat without tlast loses lock; any tlast in RESYNC regains it
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                ST_SYNC:   if ((|beat_err) && !s_axis_tlast) state_nxt = ST_RESYNC;
                ST_RESYNC: if (s_axis_tlast)                 state_nxt = ST_SYNC;
                default:   state_nxt = ST_SYNC;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        in_sync = (state == ST_SYNC);
    end

    // Expected position tracking and statistics, all updated on the accept edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            exp_frame  <= '0;
            exp_beat   <= '0;
            frames_ok  <= '0;
            err_count  <= '0;
            err_sticky <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                if (state == ST_SYNC) begin
                    if (|beat_err) begin
                        err_pulse  <= 1'b1;
                        err_sticky <= err_sticky | beat_err;
                        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                    end
                    // An earlier error in the frame would already have left SYNC,
                    // so a clean last beat means a clean frame.
                    if (s_axis_tlast) begin
                        if (!(|beat_err)) frames_ok <= frames_ok + 32'd1;
                        exp_frame <= exp_frame + 1'b1;
                        exp_beat  <= '0;
                    end else if (!(|beat_err)) begin
                        exp_beat <= exp_beat + 1'b1;
                    end
                end else if (s_axis_tlast) begin
                    exp_frame <= tdata32[31:8] + 1'b1;
                    exp_beat  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_counter_chk.sv
// Bench for axis_counter_chk: two instances (all-ones ready pattern / shaped pattern with
// a 4-bit error counter) share a reset; a per-cycle model predicts every output.
module tb_axis_counter_chk;

    localparam logic [31:0] PAT0 = 32'hFFFF_FFFF;
    localparam logic [31:0] PAT1 = 32'hA5A5_0F0F;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        enable [2];
    logic        tvalid [2];
    logic        tready [2];
    logic [31:0] tdata  [2];
    logic [3:0]  tkeep  [2];
    logic        tlast  [2];
    logic [0:0]  tuser  [2];
    logic [31:0] frames_ok [2];
    logic [15:0] ec0;
    logic [3:0]  ec1;
    logic [2:0]  sticky [2];
    logic        pulse  [2];
    logic        insync [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // model state
    bit          m_sync   [2];
    logic [23:0] m_frame  [2];
    logic [7:0]  m_beat   [2];
    logic [31:0] m_ok     [2];
    int          m_err    [2];
    logic [2:0]  m_sticky [2];
    bit          m_pulse  [2];
    bit          m_rdy    [2];
    int          m_k      [2];
    int          pulse_cnt[2];

    always #5 aclk = ~aclk;

    axis_counter_chk #(
        .DATA_W(32), .FRAME_BEATS(8), .READY_PAT(PAT0), .ERR_W(16)
    ) dut0 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable[0]),
        .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]), .s_axis_tdata(tdata[0]),
        .s_axis_tkeep(tkeep[0]), .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
        .frames_ok(frames_ok[0]), .err_count(ec0), .err_sticky(sticky[0]),
        .err_pulse(pulse[0]), .in_sync(insync[0])
    );

    axis_counter_chk #(
        .DATA_W(32), .FRAME_BEATS(8), .READY_PAT(PAT1), .ERR_W(4)
    ) dut1 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable[1]),
        .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]), .s_axis_tdata(tdata[1]),
        .s_axis_tkeep(tkeep[1]), .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
        .frames_ok(frames_ok[1]), .err_count(ec1), .err_sticky(sticky[1]),
        .err_pulse(pulse[1]), .in_sync(insync[1])
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare then advance the model; inputs are stable at the falling edge
    always @(negedge aclk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] ecv;
                logic [31:0] d;
                logic [31:0] pat;
                logic [2:0]  e;
                int          cap;
                cap = (k == 0) ? 65535 : 15;
                pat = (k == 0) ? PAT0 : PAT1;
                if (!aresetn) begin
                    m_sync[k] = 1'b1; m_frame[k] = '0; m_beat[k] = '0; m_ok[k] = '0;
                    m_err[k] = 0; m_sticky[k] = '0; m_pulse[k] = 1'b0; m_rdy[k] = 1'b0;
                    m_k[k] = 0;
                end
                ecv = (k == 0) ? ec0 : 16'(ec1);
                check($sformatf("dut%0d.tready", k),     tready[k],    m_rdy[k]);
                check($sformatf("dut%0d.frames_ok", k),  frames_ok[k], m_ok[k]);
                check($sformatf("dut%0d.err_count", k),  ecv,          m_err[k]);
                check($sformatf("dut%0d.err_sticky", k), sticky[k],    m_sticky[k]);
                check($sformatf("dut%0d.err_pulse", k),  pulse[k],     m_pulse[k]);
                check($sformatf("dut%0d.in_sync", k),    insync[k],    m_sync[k]);
                pulse_cnt[k] += int'(pulse[k]);
                if (aresetn) begin
                    m_pulse[k] = 1'b0;
                    if (tvalid[k] && tready[k]) begin
                        d = tdata[k];
                        if (m_sync[k]) begin
                            e[0] = (d != {m_frame[k], m_beat[k]});
                            e[1] = (tlast[k] != (m_beat[k] == 8'd7));
                            e[2] = (tkeep[k] != 4'hF);
                            if (e != 3'b000) begin
                                m_pulse[k]  = 1'b1;
                                m_sticky[k] = m_sticky[k] | e;
                                if (m_err[k] < cap) m_err[k]++;
                            end
                            if (tlast[k]) begin
                                if (e == 3'b000) m_ok[k] = m_ok[k] + 1;
                                m_frame[k] = m_frame[k] + 24'd1;
                                m_beat[k]  = '0;
                            end else if (e != 3'b000) begin
                                m_sync[k] = 1'b0;
                            end else begin
                                m_beat[k] = m_beat[k] + 8'd1;
                            end
                        end else if (tlast[k]) begin
                            m_frame[k] = d[31:8] + 24'd1;
                            m_beat[k]  = '0;
                            m_sync[k]  = 1'b1;
                        end
                    end
                    m_rdy[k] = enable[k] & pat[m_k[k] % 32];
                    m_k[k]++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1 aresetn = 1'b0;
        #1;
        check("rst.frames_ok0", frames_ok[0], 0);
        check("rst.tready0",    tready[0],    0);
        check("rst.in_sync0",   insync[0],    1);
        check("rst.err_count1", ec1,          0);
        check("rst.sticky0",    sticky[0],    0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        pulse_cnt[0] = 0;
        pulse_cnt[1] = 0;
    endtask

    task automatic send_beat(input int k, input logic [31:0] d, input logic [3:0] kp, input logic l);
        int n;
        bit acc;
        tvalid[k] = 1'b1; tdata[k] = d; tkeep[k] = kp; tlast[k] = l;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge aclk);
            acc = tready[k];
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d.handshake_timeout: got no tready in %0d cycles, expected tready", k, n);
        end else begin
            @(posedge aclk);
            #1;
        end
        tvalid[k] = 1'b0;
    endtask

    // mode: 0 none, 1 flip tdata bit 0, 2 drop tlast, 3 tkeep=0111, 4 flip tdata bit 4
    task automatic send_range(input int k, input logic [23:0] f, input int b0, input int b1,
                              input int bad_beat, input int mode, input bit gaps);
        for (int b = b0; b <= b1; b++) begin
            logic [31:0] d;
            logic [3:0]  kp;
            logic        l;
            d  = {f, 8'(b)};
            kp = 4'hF;
            l  = (b == 7);
            if (b == bad_beat) begin
                case (mode)
                    1: d = d ^ 32'h1;
                    2: l = 1'b0;
                    3: kp = 4'b0111;
                    4: d = d ^ 32'h10;
                    default: ;
                endcase
            end
            send_beat(k, d, kp, l);
            if (gaps && ((int'(f) + b) % 5 == 0)) idle((int'(f) + b) % 3 + 1);
        end
    endtask

    task automatic send_frame(input int k, input logic [23:0] f, input int bad_beat,
                              input int mode, input bit gaps);
        send_range(k, f, 0, 7, bad_beat, mode, gaps);
    endtask

    initial begin
        logic [7:0] rseq;
        for (int k = 0; k < 2; k++) begin
            enable[k] = 1'b1; tvalid[k] = 1'b0; tdata[k] = '0;
            tkeep[k] = '0; tlast[k] = 1'b0; tuser[k] = '0; pulse_cnt[k] = 0;
        end
        started = 1'b1;
        do_reset();

        // 100 clean frames, all-ones ready pattern, with idle gaps
        for (int f = 0; f < 100; f++) send_frame(0, 24'(f), -1, 0, 1'b1);
        idle(2);
        check("t1.frames_ok", frames_ok[0], 100);
        check("t1.err_count", ec0, 0);
        check("t1.in_sync",   insync[0], 1);

        // data error on frame 3 beat 2
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(0, 24'(f), -1, 0, 1'b0);
        send_range(0, 24'd3, 0, 2, 2, 1, 1'b0);
        check("t3.err_pulse_now", pulse[0], 1);
        check("t3.in_sync_lost",  insync[0], 0);
        send_range(0, 24'd3, 3, 7, -1, 0, 1'b0);
        for (int f = 4; f < 8; f++) send_frame(0, 24'(f), -1, 0, 1'b0);
        idle(2);
        check("t3.frames_ok",  frames_ok[0], 7);
        check("t3.err_sticky", sticky[0], 3'b001);
        check("t3.err_count",  ec0, 1);
        check("t3.pulses",     pulse_cnt[0], 1);
        check("t3.in_sync",    insync[0], 1);

        // missing tlast on frame 5 beat 7
        do_reset();
        for (int f = 0; f < 6; f++) send_frame(0, 24'(f), (f == 5) ? 7 : -1, 2, 1'b1);
        check("t4.in_sync_lost", insync[0], 0);
        send_frame(0, 24'd6, -1, 0, 1'b0);
        check("t4.in_sync_back", insync[0], 1);
        for (int f = 7; f < 10; f++) send_frame(0, 24'(f), -1, 0, 1'b0);
        idle(2);
        check("t4.frames_ok",  frames_ok[0], 8);
        check("t4.err_sticky", sticky[0], 3'b010);

        // frame id wrap through resync at 24'hFFFFFE
        do_reset();
        send_range(0, 24'd0, 0, 1, 1, 1, 1'b0);
        send_beat(0, {24'hFFFFFE, 8'd7}, 4'hF, 1'b1);
        send_frame(0, 24'hFFFFFF, -1, 0, 1'b0);
        send_frame(0, 24'h000000, -1, 0, 1'b0);
        idle(2);
        check("wrap.frames_ok", frames_ok[0], 2);
        check("wrap.err_count", ec0, 1);

        // reset in the middle of frame 2
        do_reset();
        send_frame(0, 24'd0, -1, 0, 1'b0);
        send_frame(0, 24'd1, -1, 0, 1'b0);
        send_range(0, 24'd2, 0, 3, -1, 0, 1'b0);
        check("t6.frames_ok_pre", frames_ok[0], 2);
        tvalid[0] = 1'b1; tdata[0] = {24'd2, 8'd4}; tkeep[0] = 4'hF; tlast[0] = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        check("t6.frames_ok_rst", frames_ok[0], 0);
        check("t6.tready_rst",    tready[0], 0);
        check("t6.in_sync_rst",   insync[0], 1);
        tvalid[0] = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int f = 0; f < 5; f++) send_frame(0, 24'(f), -1, 0, 1'b0);
        idle(2);
        check("t6.frames_ok", frames_ok[0], 5);
        check("t6.err_count", ec0, 0);

        // shaped ready pattern: first tready values after reset are PAT1[7:0] LSB first
        do_reset();
        @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            rseq[i] = tready[1];
        end
        check("t2.tready_seq", rseq, 8'h0F);
        @(posedge aclk);
        #1;
        for (int f = 0; f < 50; f++) send_frame(1, 24'(f), -1, 0, 1'b1);
        enable[1] = 1'b0;
        idle(40);
        enable[1] = 1'b1;
        idle(2);
        check("t2.frames_ok", frames_ok[1], 50);
        check("t2.err_count", ec1, 0);

        // keep error, then 19 last-beat data errors saturate the 4-bit counter
        send_frame(1, 24'd50, 3, 3, 1'b0);
        check("t5.sticky_keep", sticky[1], 3'b100);
        for (int f = 51; f < 65; f++) send_frame(1, 24'(f), 7, 4, 1'b0);
        check("t5.err_count_15", ec1, 4'hF);
        for (int f = 65; f < 70; f++) send_frame(1, 24'(f), 7, 4, 1'b0);
        idle(2);
        check("t5.err_count_sat", ec1, 4'hF);
        check("t5.err_sticky",    sticky[1], 3'b101);
        check("t5.frames_ok",     frames_ok[1], 50);
        check("t5.pulses",        pulse_cnt[1], 20);
        check("t5.in_sync",       insync[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
